// File: rtl/pipe_hazard_tracker.sv
// ---------------------------------------------------------------------------
// pipe_hazard_tracker
//
// Producer side of the data-hazard interface. Each instruction's destination
// register and class tags (is_load, has_link) ride down the EX/MEM/WB stage
// registers, and their EX_/MEM_ copies are what the hazard detector compares
// against. The detector's stall and the branch unit's flush are turned into
// front-end controls here. Stall statistics and a stall watchdog are kept
// alongside.
//
// Parameters
//   CNT_W      width of stall_cnt / bubble_cnt (both wrap modulo 2^CNT_W)
//   MAX_STALL  consecutive-stall limit; exceeding it sets stall_err
//
// Ports
//   clk, rst                      rising-edge clock, async active-high reset
//   ID_valid                      ID holds a real instruction
//   ID_WBSel/ID_is_load/ID_has_link  tags of the instruction in ID
//   stall_req                     load-use stall from the hazard detector
//   flush_req                     taken branch/jump resolved in ID
//   pc_we, ifid_we, ifid_clr      front-end controls (combinational)
//   EX_*, MEM_*                   stage tags consumed by the detector
//   WB_WBSel, WB_we               write-back destination and enable
//   stall_cnt, bubble_cnt         event counters
//   stall_err                     sticky watchdog flag
// ---------------------------------------------------------------------------
module pipe_hazard_tracker #(
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [4:0]       ID_WBSel,
    input  logic             ID_is_load,
    input  logic             ID_has_link,
    input  logic             stall_req,
    input  logic             flush_req,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_clr,
    output logic [4:0]       EX_WBSel,
    output logic             EX_is_load,
    output logic             EX_has_link,
    output logic [4:0]       MEM_WBSel,
    output logic             MEM_is_load,
    output logic             MEM_has_link,
    output logic [4:0]       WB_WBSel,
    output logic             WB_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             stall_err
);

    // The run-length counter only needs to reach MAX_STALL+1, where it saturates.
    localparam int RUN_W = $clog2(MAX_STALL + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL + 1);

    logic             ex_bubble;
    logic             bubble_evt;
    logic [RUN_W-1:0] run_reg;
    logic [RUN_W-1:0] run_next;

    // Stall freezes PC and IF/ID and wins over flush; the branch held in ID is
    // re-evaluated once the stall releases, so dropping the flush here is safe.
    assign pc_we    = ~stall_req;
    assign ifid_we  = ~stall_req;
    assign ifid_clr = flush_req & ~stall_req;

    // A stalled or empty ID slot enters EX as an all-zero bubble. Flush does
    // not bubble EX: the branch in ID still proceeds, only IF is squashed.
    assign ex_bubble = stall_req | ~ID_valid;

    // The squashed IF instruction of a flush is counted as a bubble too, but
    // only when a real branch sits in ID.
    assign bubble_evt = stall_req | (flush_req & ID_valid);

    always_comb begin
        run_next = '0;
        if (stall_req) begin
            run_next = (run_reg == RUN_LIMIT) ? run_reg : run_reg + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EX_WBSel     <= '0;
            EX_is_load   <= 1'b0;
            EX_has_link  <= 1'b0;
            MEM_WBSel    <= '0;
            MEM_is_load  <= 1'b0;
            MEM_has_link <= 1'b0;
            WB_WBSel     <= '0;
            WB_we        <= 1'b0;
            stall_cnt    <= '0;
            bubble_cnt   <= '0;
            stall_err    <= 1'b0;
            run_reg      <= '0;
        end else begin
            if (ex_bubble) begin
                EX_WBSel    <= '0;
                EX_is_load  <= 1'b0;
                EX_has_link <= 1'b0;
            end else begin
                EX_WBSel    <= ID_WBSel;
                EX_is_load  <= ID_is_load;
                EX_has_link <= ID_has_link;
            end

            MEM_WBSel    <= EX_WBSel;
            MEM_is_load  <= EX_is_load;
            MEM_has_link <= EX_has_link;

            // Register 0 is never written, so a bubble cannot produce a write.
            WB_WBSel     <= MEM_WBSel;
            WB_we        <= (MEM_WBSel != 5'd0);

            stall_cnt    <= stall_cnt + CNT_W'(stall_req);
            bubble_cnt   <= bubble_cnt + CNT_W'(bubble_evt);

            run_reg      <= run_next;
            stall_err    <= stall_err | (run_next == RUN_LIMIT);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
module tb_pipe_hazard_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ID_valid = 1'b0;
    logic [4:0] ID_WBSel = '0;
    logic       ID_is_load = 1'b0;
    logic       ID_has_link = 1'b0;
    logic       stall_req = 1'b0;
    logic       flush_req = 1'b0;

    // Instance a: default parameters (CNT_W=32, MAX_STALL=4)
    logic        a_pc_we, a_ifid_we, a_ifid_clr;
    logic [4:0]  a_EX_WBSel, a_MEM_WBSel, a_WB_WBSel;
    logic        a_EX_is_load, a_EX_has_link, a_MEM_is_load, a_MEM_has_link, a_WB_we;
    logic [31:0] a_stall_cnt, a_bubble_cnt;
    logic        a_stall_err;

    // Instance b: CNT_W=4, MAX_STALL=31 (counter wrap)
    logic        b_pc_we, b_ifid_we, b_ifid_clr;
    logic [4:0]  b_EX_WBSel, b_MEM_WBSel, b_WB_WBSel;
    logic        b_EX_is_load, b_EX_has_link, b_MEM_is_load, b_MEM_has_link, b_WB_we;
    logic [3:0]  b_stall_cnt, b_bubble_cnt;
    logic        b_stall_err;

    pipe_hazard_tracker dut_a (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_WBSel(ID_WBSel),
        .ID_is_load(ID_is_load), .ID_has_link(ID_has_link),
        .stall_req(stall_req), .flush_req(flush_req),
        .pc_we(a_pc_we), .ifid_we(a_ifid_we), .ifid_clr(a_ifid_clr),
        .EX_WBSel(a_EX_WBSel), .EX_is_load(a_EX_is_load), .EX_has_link(a_EX_has_link),
        .MEM_WBSel(a_MEM_WBSel), .MEM_is_load(a_MEM_is_load), .MEM_has_link(a_MEM_has_link),
        .WB_WBSel(a_WB_WBSel), .WB_we(a_WB_we),
        .stall_cnt(a_stall_cnt), .bubble_cnt(a_bubble_cnt), .stall_err(a_stall_err)
    );

    pipe_hazard_tracker #(.CNT_W(4), .MAX_STALL(31)) dut_b (
        .clk(clk), .rst(rst), .ID_valid(ID_valid), .ID_WBSel(ID_WBSel),
        .ID_is_load(ID_is_load), .ID_has_link(ID_has_link),
        .stall_req(stall_req), .flush_req(flush_req),
        .pc_we(b_pc_we), .ifid_we(b_ifid_we), .ifid_clr(b_ifid_clr),
        .EX_WBSel(b_EX_WBSel), .EX_is_load(b_EX_is_load), .EX_has_link(b_EX_has_link),
        .MEM_WBSel(b_MEM_WBSel), .MEM_is_load(b_MEM_is_load), .MEM_has_link(b_MEM_has_link),
        .WB_WBSel(b_WB_WBSel), .WB_we(b_WB_we),
        .stall_cnt(b_stall_cnt), .bubble_cnt(b_bubble_cnt), .stall_err(b_stall_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    // History of the tags that entered EX, newest last; stage k = k-th newest.
    logic [6:0]  hist[$];
    int unsigned m_stall;
    int unsigned m_bubble;
    int          m_run;
    bit          m_err_a, m_err_b;

    function automatic logic [6:0] stage(int k);
        if (hist.size() >= k) return hist[hist.size() - k];
        return 7'd0;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_stall  = 0;
        m_bubble = 0;
        m_run    = 0;
        m_err_a  = 0;
        m_err_b  = 0;
    endtask

    task automatic model_edge();
        if (rst) return;
        if (stall_req || !ID_valid) hist.push_back(7'd0);
        else hist.push_back({ID_WBSel, ID_is_load, ID_has_link});
        if (hist.size() > 3) void'(hist.pop_front());
        if (stall_req) m_stall++;
        if (stall_req || (flush_req && ID_valid)) m_bubble++;
        m_run = stall_req ? m_run + 1 : 0;
        if (m_run > 4)  m_err_a = 1;
        if (m_run > 31) m_err_b = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [6:0] ex, mem, wb;
        logic pc_e, clr_e;
        ex = stage(1); mem = stage(2); wb = stage(3);
        pc_e  = ~stall_req;
        clr_e = flush_req & ~stall_req;
        chk("a.pc_we", a_pc_we, pc_e);
        chk("a.ifid_we", a_ifid_we, pc_e);
        chk("a.ifid_clr", a_ifid_clr, clr_e);
        chk("a.EX", {a_EX_WBSel, a_EX_is_load, a_EX_has_link}, ex);
        chk("a.MEM", {a_MEM_WBSel, a_MEM_is_load, a_MEM_has_link}, mem);
        chk("a.WB_WBSel", a_WB_WBSel, wb[6:2]);
        chk("a.WB_we", a_WB_we, wb[6:2] != 0);
        chk("a.stall_cnt", a_stall_cnt, m_stall);
        chk("a.bubble_cnt", a_bubble_cnt, m_bubble);
        chk("a.stall_err", a_stall_err, m_err_a);
        chk("b.ifid_clr", b_ifid_clr, clr_e);
        chk("b.EX", {b_EX_WBSel, b_EX_is_load, b_EX_has_link}, ex);
        chk("b.WB", {b_WB_WBSel, b_WB_we}, {wb[6:2], wb[6:2] != 0});
        chk("b.stall_cnt", b_stall_cnt, m_stall % 16);
        chk("b.bubble_cnt", b_bubble_cnt, m_bubble % 16);
        chk("b.stall_err", b_stall_err, m_err_b);
    endtask

    // Inputs change only at posedge+1, outputs are sampled at posedge+1.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic v, input logic [4:0] w, input logic ld,
                          input logic lk, input logic s, input logic f);
        ID_valid = v; ID_WBSel = w; ID_is_load = ld; ID_has_link = lk;
        stall_req = s; flush_req = f;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       v;
        logic [4:0] w;
        logic       ld, lk, s, f;
        logic       e_pc, e_ifwe, e_clr;
        logic [4:0] e_exw;
        logic       e_exld, e_exlk;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1, 5'd10, 1, 0, 0, 0, 1, 1, 0, 5'd10, 1, 0};
        vecs[1] = '{1, 5'd11, 0, 1, 0, 1, 1, 1, 1, 5'd11, 0, 1};
        vecs[2] = '{1, 5'd12, 1, 1, 1, 0, 0, 0, 0, 5'd0,  0, 0};
        vecs[3] = '{1, 5'd13, 0, 0, 1, 1, 0, 0, 0, 5'd0,  0, 0};
        vecs[4] = '{0, 5'd14, 1, 1, 0, 0, 1, 1, 0, 5'd0,  0, 0};
        vecs[5] = '{0, 5'd15, 0, 0, 0, 1, 1, 1, 1, 5'd0,  0, 0};

        model_reset();
        #12;
        check_all();
        chk("reset.stall_cnt", a_stall_cnt, 0);
        chk("reset.WB_we", a_WB_we, 0);
        tick();
        rst = 1'b0;

        // Latency: r8 reaches EX, MEM, WB after edges 1, 2, 3.
        set_in(1, 5'd8, 0, 0, 0, 0);
        tick();
        chk("lat.EX_WBSel", a_EX_WBSel, 8);
        set_in(0, 5'd0, 0, 0, 0, 0);
        tick();
        chk("lat.MEM_WBSel", a_MEM_WBSel, 8);
        tick();
        chk("lat.WB_WBSel", a_WB_WBSel, 8);
        chk("lat.WB_we", a_WB_we, 1);
        $display("seq latency done");

        // Table-driven front-end / EX entry vectors.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_in(vecs[i].v, vecs[i].w, vecs[i].ld, vecs[i].lk, vecs[i].s, vecs[i].f);
            #1;
            chk("vec.pc_we", a_pc_we, vecs[i].e_pc);
            chk("vec.ifid_we", a_ifid_we, vecs[i].e_ifwe);
            chk("vec.ifid_clr", a_ifid_clr, vecs[i].e_clr);
            tick();
            chk("vec.EX", {a_EX_WBSel, a_EX_is_load, a_EX_has_link},
                {vecs[i].e_exw, vecs[i].e_exld, vecs[i].e_exlk});
            $display("vec %0d: stall=%0b flush=%0b valid=%0b EX_WBSel=%0d", i,
                     vecs[i].s, vecs[i].f, vecs[i].v, a_EX_WBSel);
        end

        // Load-use stall.
        do_reset();
        set_in(1, 5'd9, 1, 0, 0, 0);
        tick();
        set_in(1, 5'd3, 0, 0, 1, 0);
        #1;
        chk("ldu.pc_we", a_pc_we, 0);
        chk("ldu.ifid_we", a_ifid_we, 0);
        tick();
        chk("ldu.EX_bubble", {a_EX_WBSel, a_EX_is_load, a_EX_has_link}, 0);
        chk("ldu.MEM", {a_MEM_WBSel, a_MEM_is_load}, {5'd9, 1'b1});
        chk("ldu.stall_cnt", a_stall_cnt, 1);
        chk("ldu.bubble_cnt", a_bubble_cnt, 1);
        $display("seq load-use done");

        // Stall and flush together, then flush alone.
        do_reset();
        set_in(1, 5'd5, 0, 0, 1, 1);
        #1;
        chk("sf.pc_we", a_pc_we, 0);
        chk("sf.ifid_clr", a_ifid_clr, 0);
        tick();
        set_in(1, 5'd5, 0, 0, 0, 1);
        #1;
        chk("fl.pc_we", a_pc_we, 1);
        chk("fl.ifid_clr", a_ifid_clr, 1);
        tick();
        chk("fl.bubble_cnt", a_bubble_cnt, 2);
        $display("seq stall+flush done");

        // Watchdog on instance a.
        do_reset();
        set_in(1, 5'd1, 0, 0, 1, 0);
        repeat (4) tick();
        chk("wd.err_edge4", a_stall_err, 0);
        tick();
        chk("wd.err_edge5", a_stall_err, 1);
        set_in(1, 5'd1, 0, 0, 0, 0);
        repeat (2) tick();
        chk("wd.sticky", a_stall_err, 1);
        do_reset();
        chk("wd.cleared", a_stall_err, 0);
        $display("seq watchdog done");

        // Link to r0 and an empty ID slot.
        set_in(1, 5'd0, 0, 1, 0, 0);
        tick();
        chk("r0.EX", {a_EX_WBSel, a_EX_has_link}, {5'd0, 1'b1});
        set_in(0, 5'd7, 1, 1, 0, 1);
        tick();
        chk("inv.EX", {a_EX_WBSel, a_EX_is_load, a_EX_has_link}, 0);
        chk("inv.bubble_cnt", a_bubble_cnt, 0);
        tick();
        chk("r0.WB_WBSel", a_WB_WBSel, 0);
        chk("r0.WB_we", a_WB_we, 0);
        $display("seq link-r0 done");

        // 17-cycle stall: 4-bit counter wraps; reset mid-stall.
        do_reset();
        set_in(1, 5'd2, 0, 0, 1, 0);
        repeat (17) tick();
        chk("wrap.b_stall_cnt", b_stall_cnt, 1);
        chk("wrap.b_stall_err", b_stall_err, 0);
        chk("wrap.a_stall_err", a_stall_err, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst.stall_cnt", a_stall_cnt, 0);
        chk("arst.stall_err", a_stall_err, 0);
        chk("arst.MEM", {a_MEM_WBSel, a_MEM_is_load}, 0);
        chk("arst.pc_we", a_pc_we, 0);
        model_reset();
        check_all();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("arst.run_discarded", a_stall_err, 0);
        tick();
        chk("arst.run_restart", a_stall_err, 1);
        $display("seq wrap/async reset done");

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), 1'($urandom),
                   $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2);
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                tick();
            end
            $display("rnd %0d: v=%0b w=%0d s=%0b f=%0b EX=%0d WB=%0d sc=%0d bc=%0d err=%0b",
                     i, ID_valid, ID_WBSel, stall_req, flush_req, a_EX_WBSel,
                     a_WB_WBSel, a_stall_cnt, a_bubble_cnt, a_stall_err);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
